// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: sequential prefetch into a small FIFO, handed to the
// decoder over valid/ready, with epoch-tagged redirect flush and a halt/drain mode.
module fetch_prefetch_unit #(
    parameter int unsigned       ADDR_W   = 9,
    parameter int unsigned       INSTR_W  = 16,
    parameter int unsigned       DEPTH    = 2,
    parameter int unsigned       RD_LAT   = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [1:0]         mem_cmd,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  instr_pc_next,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt_req,
    output logic               halted
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned InfW = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {StRun, StStop, StHalted} state_e;
    state_e state_q, state_d;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              epoch_q;
    logic [CntW-1:0]   count_q, count_d;
    logic [InfW-1:0]   inflight_q, inflight_d;
    logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;

    // live is cleared by any redirect the entry travels through, so two quick
    // redirects cannot alias the single epoch bit
    logic [RD_LAT-1:0] pipe_valid_q, pipe_live_q, pipe_epoch_q;
    logic [ADDR_W-1:0] pipe_pc_q [RD_LAT];

    logic [INSTR_W-1:0] buf_instr_q [DEPTH];
    logic [ADDR_W-1:0]  buf_pc_q    [DEPTH];

    logic        issue, push, pop, resp;
    logic [31:0] credit_used;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + PtrW'(1);
    endfunction

    assign instr_valid   = (count_q != '0);
    assign instr         = instr_valid ? buf_instr_q[rd_ptr_q] : '0;
    assign instr_pc      = instr_valid ? buf_pc_q[rd_ptr_q] : '0;
    assign instr_pc_next = instr_pc + ADDR_W'(1);
    assign halted        = (state_q == StHalted);

    assign resp = pipe_valid_q[RD_LAT-1];
    assign push = resp & pipe_live_q[RD_LAT-1] & (pipe_epoch_q[RD_LAT-1] == epoch_q)
                  & ~redirect_valid;
    assign pop  = instr_valid & instr_ready & ~redirect_valid;

    // A pop this cycle frees a slot in time for a read issued now to land in it
    assign credit_used = 32'(count_q) + 32'(inflight_q) - 32'(pop);
    assign issue = ~reset & (state_q == StRun) & ~halt_req & ~redirect_valid
                   & (credit_used < DEPTH);

    assign mem_cmd  = {1'b0, issue};
    assign mem_addr = fetch_pc_q;

    always_comb begin
        count_d    = count_q + CntW'(push) - CntW'(pop);
        inflight_d = inflight_q + InfW'(issue) - InfW'(resp);
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            count_d    = '0;
            fetch_pc_d = redirect_pc;
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid && halt_req) begin
            state_d = StStop;
        end else begin
            case (state_q)
                StRun:    if (halt_req) state_d = StStop;
                StStop: begin
                    if (redirect_valid) state_d = StRun;
                    else if (count_q == '0 && inflight_q == '0) state_d = StHalted;
                end
                StHalted: if (redirect_valid) state_d = StRun;
                default:  state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StRun;
            fetch_pc_q   <= RESET_PC;
            epoch_q      <= 1'b0;
            count_q      <= '0;
            inflight_q   <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            pipe_valid_q <= '0;
            pipe_live_q  <= '0;
            pipe_epoch_q <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_pc_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            if (redirect_valid) begin
                epoch_q  <= ~epoch_q;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
                if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            pipe_valid_q[0] <= issue;
            pipe_live_q[0]  <= 1'b1;
            pipe_epoch_q[0] <= epoch_q;
            pipe_pc_q[0]    <= fetch_pc_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_live_q[i]  <= pipe_live_q[i-1] & ~redirect_valid;
                pipe_epoch_q[i] <= pipe_epoch_q[i-1];
                pipe_pc_q[i]    <= pipe_pc_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr_q[wr_ptr_q] <= mem_rdata;
            buf_pc_q[wr_ptr_q]    <= pipe_pc_q[RD_LAT-1];
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: two configurations (DEPTH=2/RD_LAT=1 and DEPTH=4/RD_LAT=3)
// share stimulus and are checked every cycle against a queue-based model of the fetch rules.
module tb_fetch_prefetch_unit;
    localparam int RUN = 0, STOP = 1, HALTED = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_ready = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [8:0]  redirect_pc = '0;
    logic        halt_req = 1'b0;

    logic [1:0]  mem_cmd       [2];
    logic [8:0]  mem_addr      [2];
    logic [15:0] mem_rdata     [2];
    logic [15:0] instr         [2];
    logic [8:0]  instr_pc      [2];
    logic [8:0]  instr_pc_next [2];
    logic        instr_valid   [2];
    logic        halted        [2];

    fetch_prefetch_unit #(.ADDR_W(9), .INSTR_W(16), .DEPTH(2), .RD_LAT(1), .RESET_PC(9'h000)) u_a (
        .clk(clk), .reset(reset), .mem_cmd(mem_cmd[0]), .mem_addr(mem_addr[0]),
        .mem_rdata(mem_rdata[0]), .instr(instr[0]), .instr_pc(instr_pc[0]),
        .instr_pc_next(instr_pc_next[0]), .instr_valid(instr_valid[0]),
        .instr_ready(instr_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt_req(halt_req), .halted(halted[0]));

    fetch_prefetch_unit #(.ADDR_W(9), .INSTR_W(16), .DEPTH(4), .RD_LAT(3), .RESET_PC(9'h000)) u_b (
        .clk(clk), .reset(reset), .mem_cmd(mem_cmd[1]), .mem_addr(mem_addr[1]),
        .mem_rdata(mem_rdata[1]), .instr(instr[1]), .instr_pc(instr_pc[1]),
        .instr_pc_next(instr_pc_next[1]), .instr_valid(instr_valid[1]),
        .instr_ready(instr_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt_req(halt_req), .halted(halted[1]));

    initial forever #5 clk = ~clk;

    function automatic int dep_of(input int k); return (k == 0) ? 2 : 4; endfunction
    function automatic int lat_of(input int k); return (k == 0) ? 1 : 3; endfunction
    function automatic logic [15:0] memf(input logic [8:0] a); return 16'hA000 + {7'b0, a};
    endfunction

    // Behavioural model: FIFO contents and outstanding reads as plain lists
    int          m_st   [2];
    logic [8:0]  m_fpc  [2];
    int          m_gen  [2];
    logic [15:0] fq_instr [2][8];
    logic [8:0]  fq_pc    [2][8];
    int          fq_n     [2];
    int          if_ret   [2][8];
    int          if_gen   [2][8];
    logic [8:0]  if_pc    [2][8];
    int          if_n     [2];
    // Memory: returns the word RD_LAT cycles after each observed read
    logic        mr_v [2][8];
    logic [8:0]  mr_a [2][8];

    logic        s_valid [2];
    logic [15:0] s_instr [2];
    logic [8:0]  s_pc [2], s_pcn [2], s_addr [2];
    logic [1:0]  s_cmd [2];
    logic        s_halted [2];

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string nm, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, k, cyc, act, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = RUN; m_fpc[k] = 9'h000; m_gen[k] = 0; fq_n[k] = 0; if_n[k] = 0;
            for (int j = 0; j < 8; j++) mr_v[k][j] = 1'b0;
        end
    endtask

    // One clock cycle: drive memory data, sample, compare with model, advance model
    task automatic step();
        bit pop_k [2];
        bit iss_k [2];
        for (int k = 0; k < 2; k++)
            mem_rdata[k] = mr_v[k][cyc % 8] ? memf(mr_a[k][cyc % 8]) : 16'hDEAD;
        #2;
        for (int k = 0; k < 2; k++) begin
            s_valid[k] = instr_valid[k]; s_instr[k] = instr[k]; s_pc[k] = instr_pc[k];
            s_pcn[k] = instr_pc_next[k]; s_cmd[k] = mem_cmd[k]; s_addr[k] = mem_addr[k];
            s_halted[k] = halted[k];
        end
        for (int k = 0; k < 2; k++) begin
            bit ev;
            int used;
            ev = (fq_n[k] > 0);
            pop_k[k] = ev && instr_ready && !redirect_valid;
            used = fq_n[k] + if_n[k] - (pop_k[k] ? 1 : 0);
            iss_k[k] = !reset && m_st[k] == RUN && !halt_req && !redirect_valid
                       && used < dep_of(k);
            check("instr_valid", k, 32'(s_valid[k]), 32'(ev));
            check("instr", k, 32'(s_instr[k]), ev ? 32'(fq_instr[k][0]) : 32'h0);
            if (ev) begin
                check("instr_pc", k, 32'(s_pc[k]), 32'(fq_pc[k][0]));
                check("instr_pc_next", k, 32'(s_pcn[k]), 32'(9'(fq_pc[k][0] + 9'd1)));
            end
            check("mem_cmd", k, 32'(s_cmd[k]), iss_k[k] ? 32'h1 : 32'h0);
            if (iss_k[k]) check("mem_addr", k, 32'(s_addr[k]), 32'(m_fpc[k]));
            check("halted", k, 32'(s_halted[k]), 32'(m_st[k] == HALTED));
        end
        for (int k = 0; k < 2; k++) begin
            int old_fq, old_if;
            bit pushv;
            logic [8:0] pp;
            old_fq = fq_n[k]; old_if = if_n[k]; pushv = 0; pp = '0;
            mr_v[k][cyc % 8] = 1'b0;
            if (s_cmd[k] == 2'b01) begin
                mr_v[k][(cyc + lat_of(k)) % 8] = 1'b1;
                mr_a[k][(cyc + lat_of(k)) % 8] = s_addr[k];
            end
            if (reset) begin
                m_st[k] = RUN; m_fpc[k] = 9'h000; fq_n[k] = 0; if_n[k] = 0; m_gen[k]++;
            end else begin
                if (if_n[k] > 0 && if_ret[k][0] == cyc) begin
                    pushv = (if_gen[k][0] == m_gen[k]) && !redirect_valid;
                    pp = if_pc[k][0];
                    for (int j = 0; j < 7; j++) begin
                        if_ret[k][j] = if_ret[k][j+1]; if_gen[k][j] = if_gen[k][j+1];
                        if_pc[k][j] = if_pc[k][j+1];
                    end
                    if_n[k]--;
                end
                if (redirect_valid) begin
                    fq_n[k] = 0; m_gen[k]++; m_fpc[k] = redirect_pc;
                end else begin
                    if (pop_k[k]) begin
                        for (int j = 0; j < 7; j++) begin
                            fq_instr[k][j] = fq_instr[k][j+1]; fq_pc[k][j] = fq_pc[k][j+1];
                        end
                        fq_n[k]--;
                    end
                    if (pushv) begin
                        fq_instr[k][fq_n[k]] = memf(pp); fq_pc[k][fq_n[k]] = pp; fq_n[k]++;
                    end
                end
                if (iss_k[k]) begin
                    if_ret[k][if_n[k]] = cyc + lat_of(k); if_gen[k][if_n[k]] = m_gen[k];
                    if_pc[k][if_n[k]] = m_fpc[k]; if_n[k]++;
                    m_fpc[k] = m_fpc[k] + 9'd1;
                end
                if (redirect_valid && halt_req) m_st[k] = STOP;
                else if (m_st[k] == RUN && halt_req) m_st[k] = STOP;
                else if (m_st[k] == STOP && redirect_valid) m_st[k] = RUN;
                else if (m_st[k] == STOP && old_fq == 0 && old_if == 0) m_st[k] = HALTED;
                else if (m_st[k] == HALTED && redirect_valid) m_st[k] = RUN;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int issues, pops, ngot, saw5, found;
        logic [8:0] got [2];
        logic [8:0] pcn0;
        model_reset();
        @(negedge clk);

        // Reset then free-running fetch: first read at 0, A000..A002 back to back
        reset = 1'b1; instr_ready = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        check("t1_first_cmd", 0, 32'(s_cmd[0]), 32'h1);
        check("t1_first_addr", 0, 32'(s_addr[0]), 32'h0);
        step();
        check("t1_no_valid_yet", 0, 32'(s_valid[0]), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t1_valid", 0, 32'(s_valid[0]), 32'h1);
            check("t1_instr", 0, 32'(s_instr[0]), 32'hA000 + 32'(i));
            check("t1_pc", 0, 32'(s_pc[0]), 32'(i));
        end

        // Decoder stalled: exactly two reads, then resume at 2 once ready rises
        reset = 1'b1; instr_ready = 1'b0;
        step();
        reset = 1'b0;
        issues = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (s_cmd[0] == 2'b01) begin
                check("t2_addr", 0, 32'(s_addr[0]), 32'(issues));
                issues++;
            end
        end
        check("t2_issues", 0, 32'(issues), 32'd2);
        check("t2_idle_cmd", 0, 32'(s_cmd[0]), 32'h0);
        instr_ready = 1'b1;
        step();
        check("t2_pop0_pc", 0, 32'(s_pc[0]), 32'h0);
        check("t2_resume_addr", 0, 32'(s_cmd[0] == 2'b01 ? s_addr[0] : 9'h1ff), 32'h2);
        step();
        check("t2_pop1_pc", 0, 32'(s_pc[0]), 32'h1);

        // Redirect while the read of 5 is in flight
        reset = 1'b1;
        step();
        reset = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step();
            if (s_cmd[0] == 2'b01 && s_addr[0] == 9'h005) found = 1;
        end
        check("t3_saw_addr5", 0, 32'(found), 32'h1);
        redirect_valid = 1'b1; redirect_pc = 9'h040;
        step();
        redirect_valid = 1'b0;
        ngot = 0; saw5 = 0;
        for (int i = 0; i < 10 && ngot < 2; i++) begin
            step();
            if (s_valid[0]) begin
                if (s_pc[0] == 9'h005) saw5 = 1;
                got[ngot] = s_pc[0]; ngot++;
            end
        end
        check("t3_count", 0, 32'(ngot), 32'd2);
        check("t3_first", 0, 32'(got[0]), 32'h040);
        check("t3_second", 0, 32'(got[1]), 32'h041);
        check("t3_no_stale", 0, 32'(saw5), 32'h0);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 9'h1FF;
        step();
        redirect_valid = 1'b0;
        ngot = 0; pcn0 = '0;
        for (int i = 0; i < 10 && ngot < 2; i++) begin
            step();
            if (s_valid[0]) begin
                if (ngot == 0) pcn0 = s_pcn[0];
                got[ngot] = s_pc[0]; ngot++;
            end
        end
        check("t4_pc_top", 0, 32'(got[0]), 32'h1FF);
        check("t4_pc_next_wrap", 0, 32'(pcn0), 32'h000);
        check("t4_pc_wrapped", 0, 32'(got[1]), 32'h000);

        // Halt with words buffered and one read outstanding, then restart by redirect
        reset = 1'b1; instr_ready = 1'b0;
        step();
        reset = 1'b0;
        step(); step();
        halt_req = 1'b1;
        step();
        check("t5_halt_no_issue", 0, 32'(s_cmd[0]), 32'h0);
        halt_req = 1'b0; instr_ready = 1'b1;
        pops = 0; issues = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_valid[0]) pops++;
            if (s_cmd[0] == 2'b01) issues++;
        end
        check("t5_pops", 0, 32'(pops), 32'd2);
        check("t5_issues", 0, 32'(issues), 32'd0);
        check("t5_halted", 0, 32'(s_halted[0]), 32'h1);
        redirect_valid = 1'b1; redirect_pc = 9'h010;
        step();
        redirect_valid = 1'b0;
        step();
        check("t5_unhalted", 0, 32'(s_halted[0]), 32'h0);
        check("t5_restart_cmd", 0, 32'(s_cmd[0]), 32'h1);
        check("t5_restart_addr", 0, 32'(s_addr[0]), 32'h010);

        // Reset mid-stream on the deep, long-latency configuration
        for (int i = 0; i < 30; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        instr_ready = 1'b1; reset = 1'b1;
        step();
        check("t6_reset_cmd", 1, 32'(s_cmd[1]), 32'h0);
        reset = 1'b0;
        step();
        check("t6_valid", 1, 32'(s_valid[1]), 32'h0);
        check("t6_instr", 1, 32'(s_instr[1]), 32'h0);
        check("t6_halted", 1, 32'(s_halted[1]), 32'h0);
        check("t6_first_cmd", 1, 32'(s_cmd[1]), 32'h1);
        check("t6_first_addr", 1, 32'(s_addr[1]), 32'h0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 199) == 0);
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = 9'($urandom);
            halt_req       = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
